regfile_writeport: RTL and testbench

- Architectural register file for the non-pipelined multi-cycle MIPS core: 32 x 32-bit GPRs, two read ports and one write port.
- Its write port is the receiving end of the writeback stage. It accepts writedata, the destination register and RegWrite, and commits them on the clock edge while the global one-hot state is WRITEBACK.
- Its read ports latch operands for ALU/memory during DECODE.
- It is sequential state-holding storage with state-gated capture. It is not a combinational wrapper.

---
 rtl/regfile_writeport_pkg.sv | 15 +
 rtl/regfile_writeport_if.sv | 30 +++
 rtl/regfile_writeport_onehot_check.sv | 10 +
 rtl/regfile_writeport.sv | 80 ++++++++
 tb/tb_regfile_writeport.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/regfile_writeport_pkg.sv
// Shared MIPS control encodings: one-hot FSM states and special register numbers.
package mips_pkg;

  localparam logic [5:0] ST_FETCH  = 6'b000001;
  localparam logic [5:0] ST_DECODE = 6'b000010;
  localparam logic [5:0] ST_EXEC   = 6'b000100;
  localparam logic [5:0] ST_MEM    = 6'b001000;
  localparam logic [5:0] ST_MEMWB  = 6'b010000;
  localparam logic [5:0] ST_WB     = 6'b100000;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [4:0] REG_GP   = 5'd28;
  localparam logic [4:0] REG_SP   = 5'd29;

endpackage

// File: rtl/regfile_writeport_if.sv
// Register-file bus: control/writeback side drives state, write and read
// addresses; the register file returns registered operands and status.
// Handshake: there is no valid/ready pair. A write is offered by RegWrite=1 while
// state==ST_WB and is always accepted at that edge; write_ack reports the commit
// during the following cycle. Operands are requested by state==ST_DECODE and are
// valid from the following cycle until the next DECODE.
interface regfile_writeport_if #(
  parameter int DATA_W = 32
);
  logic [5:0]        state;
  logic              RegWrite;
  logic [4:0]        WriteReg;
  logic [DATA_W-1:0] writedata;
  logic [4:0]        ReadReg1;
  logic [4:0]        ReadReg2;
  logic [DATA_W-1:0] ReadData1;
  logic [DATA_W-1:0] ReadData2;
  logic              write_ack;
  logic              state_err;

  modport master (
    output state, RegWrite, WriteReg, writedata, ReadReg1, ReadReg2,
    input  ReadData1, ReadData2, write_ack, state_err
  );

  modport slave (
    input  state, RegWrite, WriteReg, writedata, ReadReg1, ReadReg2,
    output ReadData1, ReadData2, write_ack, state_err
  );
endinterface

// File: rtl/regfile_writeport_onehot_check.sv
// Flags whether the 6-bit control state has exactly one bit set.
module onehot_check (
  input  logic [5:0] state,
  output logic       valid
);
  // Non-zero and clearing the lowest set bit leaves nothing.
  always_comb begin
    valid = (state != 6'd0) && ((state & (state - 6'd1)) == 6'd0);
  end
endmodule

// File: rtl/regfile_writeport.sv
// 32 x 32 architectural register file for the multi-cycle MIPS core.
// Writes commit only in WB, operands are captured only in DECODE, and any
// non-one-hot state suppresses both and raises a sticky error.
module regfile_writeport
  import mips_pkg::*;
#(
  parameter int          DATA_W  = 32,
  parameter int          NREGS   = 32,
  parameter logic [31:0] SP_INIT = 32'h0000_3FFC,
  parameter logic [31:0] GP_INIT = 32'h0000_1800
) (
  input logic               clk,
  input logic               rst,
  regfile_writeport_if.slave wp
);

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];
  logic [DATA_W-1:0] rd1_q, rd1_d;
  logic [DATA_W-1:0] rd2_q, rd2_d;
  logic              ack_q, ack_d;
  logic              err_q, err_d;
  logic              state_ok;
  logic              wr_en;
  logic              rd_en;

  onehot_check u_onehot_check (
    .state (wp.state),
    .valid (state_ok)
  );

  // Next-state: gated write, gated operand capture, sticky error.
  always_comb begin
    wr_en = state_ok && (wp.state == ST_WB) && wp.RegWrite && (wp.WriteReg != REG_ZERO);
    rd_en = state_ok && (wp.state == ST_DECODE);

    regs_d = regs_q;
    if (wr_en) begin
      regs_d[wp.WriteReg] = wp.writedata;
    end

    rd1_d = rd1_q;
    rd2_d = rd2_q;
    if (rd_en) begin
      // $0 is hard-wired to zero regardless of storage contents.
      rd1_d = (wp.ReadReg1 == REG_ZERO) ? '0 : regs_q[wp.ReadReg1];
      rd2_d = (wp.ReadReg2 == REG_ZERO) ? '0 : regs_q[wp.ReadReg2];
    end

    ack_d = wr_en;
    err_d = err_q | ~state_ok;
  end

  // State registers; reset loads $gp/$sp and discards any pending write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
      regs_q[REG_GP] <= GP_INIT[DATA_W-1:0];
      regs_q[REG_SP] <= SP_INIT[DATA_W-1:0];
      rd1_q <= '0;
      rd2_q <= '0;
      ack_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      regs_q <= regs_d;
      rd1_q  <= rd1_d;
      rd2_q  <= rd2_d;
      ack_q  <= ack_d;
      err_q  <= err_d;
    end
  end

  assign wp.ReadData1 = rd1_q;
  assign wp.ReadData2 = rd2_q;
  assign wp.write_ack = ack_q;
  assign wp.state_err = err_q;

endmodule

// File: tb/tb_regfile_writeport.sv
// Bench for regfile_writeport: directed test-plan sequence with literal
// expectations, then random traffic checked every cycle against a reference model.
module tb_regfile_writeport;
  import mips_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  regfile_writeport_if #(.DATA_W(32)) wp_if ();

  regfile_writeport dut (
    .clk (clk),
    .rst (rst),
    .wp  (wp_if.slave)
  );

  int total = 0;
  int bad   = 0;

  // ---------------- reference model ----------------
  logic [31:0] m_regs [32];
  logic [31:0] m_rd1, m_rd2;
  logic        m_ack, m_err;
  bit          m_valid = 0;

  // Model advances on each rising edge from the inputs presented for that edge.
  always @(posedge clk) begin
    if (rst) begin
      foreach (m_regs[i]) m_regs[i] = 32'd0;
      m_regs[28] = 32'h0000_1800;
      m_regs[29] = 32'h0000_3FFC;
      m_rd1 = 32'd0; m_rd2 = 32'd0; m_ack = 1'b0; m_err = 1'b0;
      m_valid = 1;
    end else if (m_valid) begin
      m_ack = 1'b0;
      if ($countones(wp_if.state) != 1) begin
        m_err = 1'b1;
      end else if (wp_if.state == ST_DECODE) begin
        m_rd1 = m_regs[wp_if.ReadReg1];
        m_rd2 = m_regs[wp_if.ReadReg2];
      end else if (wp_if.state == ST_WB && wp_if.RegWrite && wp_if.WriteReg != 5'd0) begin
        m_regs[wp_if.WriteReg] = wp_if.writedata;
        m_ack = 1'b1;
      end
    end
  end

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every cycle against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_valid) begin
      exp_q.push_back(m_rd1);
      exp_q.push_back(m_rd2);
      exp_q.push_back({31'd0, m_ack});
      exp_q.push_back({31'd0, m_err});
      chk("model_rd1", wp_if.ReadData1, exp_q.pop_front());
      chk("model_rd2", wp_if.ReadData2, exp_q.pop_front());
      chk("model_ack", {31'd0, wp_if.write_ack}, exp_q.pop_front());
      chk("model_err", {31'd0, wp_if.state_err}, exp_q.pop_front());
    end
  end

  // ---------------- driver ----------------
  task automatic cyc(input logic [5:0] st, input logic rw, input logic [4:0] wr,
                     input logic [31:0] wd, input logic [4:0] r1, input logic [4:0] r2,
                     input logic r);
    rst               = r;
    wp_if.state       = st;
    wp_if.RegWrite    = rw;
    wp_if.WriteReg    = wr;
    wp_if.writedata   = wd;
    wp_if.ReadReg1    = r1;
    wp_if.ReadReg2    = r2;
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [5:0] legal_st [6];

  initial begin
    legal_st[0] = ST_FETCH; legal_st[1] = ST_DECODE; legal_st[2] = ST_EXEC;
    legal_st[3] = ST_MEM;   legal_st[4] = ST_MEMWB;  legal_st[5] = ST_WB;

    // Reset held two cycles.
    cyc(ST_FETCH, 1'b1, 5'd8, 32'hFFFF_FFFF, 5'd0, 5'd0, 1'b1);
    cyc(ST_FETCH, 1'b1, 5'd8, 32'hFFFF_FFFF, 5'd0, 5'd0, 1'b1);
    chk("rst_rd1", wp_if.ReadData1, 32'd0);
    chk("rst_ack", {31'd0, wp_if.write_ack}, 32'd0);
    chk("rst_err", {31'd0, wp_if.state_err}, 32'd0);

    cyc(ST_DECODE, 1'b0, 5'd0, 32'd0, 5'd29, 5'd28, 1'b0);
    chk("sp_init", wp_if.ReadData1, 32'h0000_3FFC);
    chk("gp_init", wp_if.ReadData2, 32'h0000_1800);
    cyc(ST_DECODE, 1'b0, 5'd0, 32'd0, 5'd5, 5'd0, 1'b0);
    chk("r5_init", wp_if.ReadData1, 32'd0);
    chk("r0_init", wp_if.ReadData2, 32'd0);

    // Basic write.
    cyc(ST_WB, 1'b1, 5'd8, 32'hDEAD_BEEF, 5'd0, 5'd0, 1'b0);
    chk("wb_ack", {31'd0, wp_if.write_ack}, 32'd1);
    cyc(ST_FETCH, 1'b0, 5'd8, 32'd0, 5'd0, 5'd0, 1'b0);
    chk("ack_pulse", {31'd0, wp_if.write_ack}, 32'd0);
    cyc(ST_DECODE, 1'b0, 5'd0, 32'd0, 5'd8, 5'd0, 1'b0);
    chk("r8_read", wp_if.ReadData1, 32'hDEAD_BEEF);

    // State gating.
    cyc(ST_MEM, 1'b1, 5'd8, 32'h1111_1111, 5'd0, 5'd0, 1'b0);
    chk("mem_noack", {31'd0, wp_if.write_ack}, 32'd0);
    cyc(ST_EXEC, 1'b1, 5'd8, 32'h2222_2222, 5'd0, 5'd0, 1'b0);
    chk("exec_noack", {31'd0, wp_if.write_ack}, 32'd0);
    cyc(ST_DECODE, 1'b0, 5'd0, 32'd0, 5'd8, 5'd8, 1'b0);
    chk("r8_gated", wp_if.ReadData1, 32'hDEAD_BEEF);

    // $0 write.
    cyc(ST_WB, 1'b1, 5'd0, 32'h0000_1234, 5'd0, 5'd0, 1'b0);
    chk("r0_noack", {31'd0, wp_if.write_ack}, 32'd0);
    cyc(ST_DECODE, 1'b0, 5'd0, 32'd0, 5'd0, 5'd8, 1'b0);
    chk("r0_zero", wp_if.ReadData1, 32'd0);

    // Operand hold.
    cyc(ST_DECODE, 1'b0, 5'd0, 32'd0, 5'd8, 5'd0, 1'b0);
    cyc(ST_WB, 1'b1, 5'd8, 32'h0000_0005, 5'd8, 5'd0, 1'b0);
    chk("hold_wb", wp_if.ReadData1, 32'hDEAD_BEEF);
    cyc(ST_FETCH, 1'b0, 5'd0, 32'd0, 5'd8, 5'd0, 1'b0);
    chk("hold_fetch", wp_if.ReadData1, 32'hDEAD_BEEF);
    cyc(ST_DECODE, 1'b0, 5'd0, 32'd0, 5'd8, 5'd0, 1'b0);
    chk("hold_new", wp_if.ReadData1, 32'h0000_0005);

    // Illegal state, then reset with a pending write.
    cyc(6'b100010, 1'b1, 5'd9, 32'h0000_00AA, 5'd9, 5'd0, 1'b0);
    chk("ill_err", {31'd0, wp_if.state_err}, 32'd1);
    chk("ill_noack", {31'd0, wp_if.write_ack}, 32'd0);
    chk("ill_nocap", wp_if.ReadData1, 32'h0000_0005);
    cyc(6'b000000, 1'b1, 5'd9, 32'h0000_00AA, 5'd9, 5'd0, 1'b0);
    cyc(ST_DECODE, 1'b0, 5'd0, 32'd0, 5'd9, 5'd0, 1'b0);
    chk("err_sticky", {31'd0, wp_if.state_err}, 32'd1);
    chk("r9_nowrite", wp_if.ReadData1, 32'd0);
    cyc(ST_WB, 1'b1, 5'd9, 32'h0000_0077, 5'd0, 5'd0, 1'b1);
    chk("rst_err_clr", {31'd0, wp_if.state_err}, 32'd0);
    chk("rst_noack", {31'd0, wp_if.write_ack}, 32'd0);
    cyc(ST_DECODE, 1'b0, 5'd0, 32'd0, 5'd9, 5'd29, 1'b0);
    chk("r9_rst", wp_if.ReadData1, 32'd0);
    chk("sp_rst", wp_if.ReadData2, 32'h0000_3FFC);

    // Random traffic checked by the per-cycle model compare.
    for (int i = 0; i < 600; i++) begin
      logic [5:0] st;
      if ($urandom_range(0, 19) == 0) st = 6'($urandom_range(0, 63));
      else st = legal_st[$urandom_range(0, 5)];
      cyc(st, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
          5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
          ($urandom_range(0, 59) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
